// File: rtl/binary_mul_pipe_bi.sv
// rtl/binary_mul_pipe_bi.sv - fully pipelined signed/unsigned binary multiplier
// Optional saturation of overflowing results: define BINARY_MUL_SAT_EN.
module binary_mul_pipe_bi #(
    parameter int WIDTH      = 5,
    parameter int STAGE_BITS = 1,
    parameter int OUT_W      = 2*WIDTH-1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    output logic [OUT_W-1:0] P,
    output logic             ovf
);
    localparam int K  = WIDTH / STAGE_BITS;
    localparam int W2 = 2 * WIDTH;

    // Index 0 is the capture stage; index k holds the result of partial-product stage k.
    logic [WIDTH-1:0] a_q   [0:K-1];
    logic [WIDTH-1:0] b_q   [0:K-1];
    logic             m_q   [0:K];
    logic             v_q   [0:K];
    logic [W2-1:0]    acc_q [0:K];
    logic [W2-1:0]    acc_d [1:K];

    logic             out_valid_q;
    logic [OUT_W-1:0] p_q;
    logic             ovf_q;
    logic [OUT_W-1:0] p_d;
    logic             ovf_d;
    logic [W2-1:0]    f;

    // Adds STAGE_BITS multiples of A starting at multiplier bit 'base'; B's MSB weighs -2^(WIDTH-1) when signed.
    function automatic logic [W2-1:0] pp_step(input logic [W2-1:0]    acc,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic             mode,
                                              input int               base);
        logic [W2-1:0]    a_ext;
        logic [W2-1:0]    term;
        logic [W2-1:0]    sum;
        logic [WIDTH-1:0] bs;
        a_ext = mode ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        term  = a_ext << base;
        bs    = b >> base;
        sum   = acc;
        for (int j = 0; j < STAGE_BITS; j++) begin
            if (bs[0]) begin
                if (mode && (base + j == WIDTH - 1))
                    sum = sum - term;
                else
                    sum = sum + term;
            end
            term = term << 1;
            bs   = bs >> 1;
        end
        return sum;
    endfunction

    always_comb begin
        for (int k = 1; k <= K; k++)
            acc_d[k] = pp_step(acc_q[k-1], a_q[k-1], b_q[k-1], m_q[k-1], (k-1)*STAGE_BITS);
    end

    assign f = acc_q[K];

    generate
        if (OUT_W == W2) begin : g_full
            assign ovf_d = 1'b0;
        end else begin : g_narrow
            assign ovf_d = m_q[K] ? (f[W2-1:OUT_W-1] != {(W2-OUT_W+1){f[W2-1]}})
                                  : (f[W2-1:OUT_W] != '0);
        end
    endgenerate

`ifdef BINARY_MUL_SAT_EN
    always_comb begin
        p_d = f[OUT_W-1:0];
        if (ovf_d) begin
            if (!m_q[K])
                p_d = '1;
            else if (f[W2-1])
                p_d = {1'b1, {(OUT_W-1){1'b0}}};
            else
                p_d = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end
`else
    assign p_d = f[OUT_W-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < K; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
            for (int k = 0; k <= K; k++) begin
                m_q[k]   <= 1'b0;
                v_q[k]   <= 1'b0;
                acc_q[k] <= '0;
            end
            out_valid_q <= 1'b0;
            p_q         <= '0;
            ovf_q       <= 1'b0;
        end else if (en) begin
            a_q[0]   <= A;
            b_q[0]   <= B;
            m_q[0]   <= signed_mode;
            v_q[0]   <= in_valid;
            acc_q[0] <= '0;
            for (int k = 1; k < K; k++) begin
                a_q[k] <= a_q[k-1];
                b_q[k] <= b_q[k-1];
            end
            for (int k = 1; k <= K; k++) begin
                m_q[k]   <= m_q[k-1];
                v_q[k]   <= v_q[k-1];
                acc_q[k] <= acc_d[k];
            end
            // Result registers only load on a valid op so bubbles leave the last product visible.
            out_valid_q <= v_q[K];
            if (v_q[K]) begin
                p_q   <= p_d;
                ovf_q <= ovf_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign P         = p_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_binary_mul_pipe_bi.sv
// tb/tb_binary_mul_pipe_bi.sv - randomized self-checking bench for binary_mul_pipe_bi
module tb_binary_mul_pipe_bi;
    localparam int L5 = 6;
    localparam int L8 = 5;

    logic       clk;
    logic       rst;
    logic       en;
    logic       in_valid;
    logic       signed_mode;
    logic [4:0] A;
    logic [4:0] B;
    logic       out_valid;
    logic [8:0] P;
    logic       ovf;

    logic        v8;
    logic        m8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        out_valid8;
    logic [15:0] P8;
    logic        ovf8;

    int passed = 0;
    int total  = 0;

    int         ecnt = 0;
    longint     exp_p [int];
    logic       exp_o [int];
    logic       mdl_v = 1'b0;
    logic [8:0] mdl_p = '0;
    logic       mdl_o = 1'b0;

    binary_mul_pipe_bi dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .signed_mode(signed_mode),
        .A(A), .B(B), .out_valid(out_valid), .P(P), .ovf(ovf)
    );

    binary_mul_pipe_bi #(.WIDTH(8), .STAGE_BITS(2), .OUT_W(16)) dut8 (
        .clk(clk), .rst(rst), .en(en), .in_valid(v8), .signed_mode(m8),
        .A(a8), .B(b8), .out_valid(out_valid8), .P(P8), .ovf(ovf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void ref_mul(input int w, input int ow, input logic m,
                                    input longint a, input longint b,
                                    output longint p, output logic o);
        longint av, bv, f, half, full;
        av = a;
        bv = b;
        if (m && a >= (longint'(1) << (w-1))) av = a - (longint'(1) << w);
        if (m && b >= (longint'(1) << (w-1))) bv = b - (longint'(1) << w);
        f    = av * bv;
        half = longint'(1) << (ow-1);
        full = longint'(1) << ow;
        o    = m ? ((f < -half) || (f > half - 1)) : (f >= full);
        p    = f & (full - 1);
`ifdef BINARY_MUL_SAT_EN
        if (o) p = !m ? full - 1 : ((f > 0) ? half - 1 : half);
`endif
    endfunction

    task automatic tick(input logic e, input logic v, input logic m, input logic [4:0] a, input logic [4:0] b);
        longint p;
        logic   o;
        longint t;
        @(negedge clk);
        en = e; in_valid = v; signed_mode = m; A = a; B = b;
        @(posedge clk);
        if (e && !rst) begin
            ecnt++;
            if (v) begin
                ref_mul(5, 9, m, longint'(a), longint'(b), p, o);
                exp_p[ecnt+L5] = p;
                exp_o[ecnt+L5] = o;
            end
            mdl_v = exp_p.exists(ecnt);
            if (mdl_v) begin
                t     = exp_p[ecnt];
                mdl_p = t[8:0];
                mdl_o = exp_o[ecnt];
            end
        end
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; signed_mode = 1'b0; A = '0; B = '0;
        v8 = 1'b0; m8 = 1'b0; a8 = '0; b8 = '0;
        #12;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
        total++; if (P !== 9'd0) $display("FAIL reset_P got %0d want 0", P); else passed++;
        total++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", ovf); else passed++;
        total++; if (out_valid8 !== 1'b0 || P8 !== 16'd0 || ovf8 !== 1'b0)
            $display("FAIL reset_wide got v=%b P=%0d ovf=%b want 0/0/0", out_valid8, P8, ovf8); else passed++;
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic test_signed_sweep;
        for (int i = -16; i < 16 + L5 + 1; i++) begin
            for (int j = -16; j < 16; j++) begin
                if (i < 16)
                    tick(1'b1, 1'b1, 1'b1, 5'(i), 5'(j));
                else if (j == -16)
                    tick(1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
                else
                    continue;
                total++;
                if (out_valid !== mdl_v || P !== mdl_p || ovf !== mdl_o)
                    $display("FAIL signed_sweep edge %0d got v=%b P=%0d ovf=%b want v=%b P=%0d ovf=%b",
                             ecnt, out_valid, P, ovf, mdl_v, mdl_p, mdl_o);
                else passed++;
            end
        end
    endtask

    task automatic test_unsigned;
        for (int i = 0; i < 60 + L5 + 1; i++) begin
            if (i == 0)       tick(1'b1, 1'b1, 1'b0, 5'd31, 5'd31);
            else if (i == 1)  tick(1'b1, 1'b1, 1'b0, 5'd20, 5'd25);
            else if (i < 60)  tick(1'b1, 1'($urandom_range(0, 3) != 0), 1'b0, 5'($urandom), 5'($urandom));
            else              tick(1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
            total++;
            if (out_valid !== mdl_v || P !== mdl_p || ovf !== mdl_o)
                $display("FAIL unsigned edge %0d got v=%b P=%0d ovf=%b want v=%b P=%0d ovf=%b",
                         ecnt, out_valid, P, ovf, mdl_v, mdl_p, mdl_o);
            else passed++;
        end
    endtask

    task automatic test_alternating;
        for (int i = 0; i < 10 + L5 + 1; i++) begin
            if (i < 10) tick(1'b1, 1'b1, 1'(i % 2), 5'b11111, 5'b00011);
            else        tick(1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
            total++;
            if (out_valid !== mdl_v || P !== mdl_p || ovf !== mdl_o)
                $display("FAIL alternating edge %0d got v=%b P=%0d ovf=%b want v=%b P=%0d ovf=%b",
                         ecnt, out_valid, P, ovf, mdl_v, mdl_p, mdl_o);
            else passed++;
        end
    endtask

    task automatic test_stall;
        int ones;
        ones = 0;
        for (int i = 0; i < 16; i++) begin
            case (i)
                0:             tick(1'b1, 1'b1, 1'b1, 5'd3, 5'd4);
                1:             tick(1'b1, 1'b0, 1'b1, 5'd0, 5'd0);
                2:             tick(1'b1, 1'b1, 1'b1, 5'h19, 5'd2);
                5, 6, 7, 8:    tick(1'b0, 1'b1, 1'b1, 5'd9, 5'd9);
                default:       tick(1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
            endcase
            if (en && out_valid === 1'b1) ones++;
            total++;
            if (out_valid !== mdl_v || P !== mdl_p || ovf !== mdl_o)
                $display("FAIL stall edge %0d got v=%b P=%0d ovf=%b want v=%b P=%0d ovf=%b",
                         ecnt, out_valid, P, ovf, mdl_v, mdl_p, mdl_o);
            else passed++;
        end
        total++; if (ones !== 2) $display("FAIL stall_result_count got %0d want 2", ones); else passed++;
    endtask

    task automatic test_random_stall;
        for (int i = 0; i < 300 + L5 + 1; i++) begin
            if (i < 300) tick(1'($urandom_range(0, 3) != 0), 1'($urandom % 2), 1'($urandom % 2), 5'($urandom), 5'($urandom));
            else         tick(1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
            total++;
            if (out_valid !== mdl_v || P !== mdl_p || ovf !== mdl_o)
                $display("FAIL random_stall edge %0d got v=%b P=%0d ovf=%b want v=%b P=%0d ovf=%b",
                         ecnt, out_valid, P, ovf, mdl_v, mdl_p, mdl_o);
            else passed++;
        end
    endtask

    task automatic test_async_reset;
        tick(1'b1, 1'b1, 1'b0, 5'd27, 5'd19);
        tick(1'b1, 1'b1, 1'b0, 5'd7, 5'd9);
        tick(1'b1, 1'b1, 1'b1, 5'h1E, 5'd6);
        tick(1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
        #2 rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || P !== 9'd0 || ovf !== 1'b0)
            $display("FAIL async_reset_immediate got v=%b P=%0d ovf=%b want 0/0/0", out_valid, P, ovf);
        else passed++;
        exp_p.delete();
        exp_o.delete();
        mdl_v = 1'b0; mdl_p = '0; mdl_o = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 10 + L5 + 1; i++) begin
            if (i == 8) tick(1'b1, 1'b1, 1'b1, 5'h1D, 5'd5);
            else        tick(1'b1, 1'b0, 1'b0, 5'd0, 5'd0);
            total++;
            if (out_valid !== mdl_v || P !== mdl_p || ovf !== mdl_o)
                $display("FAIL async_reset edge %0d got v=%b P=%0d ovf=%b want v=%b P=%0d ovf=%b",
                         ecnt, out_valid, P, ovf, mdl_v, mdl_p, mdl_o);
            else passed++;
        end
    endtask

    task automatic test_wide;
        longint ep [int];
        logic   eo [int];
        longint p;
        logic   o;
        longint t;
        logic   want_v;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            en = 1'b1;
            if (i < 8) begin
                v8 = 1'b1;
                a8 = (i == 0) ? 8'h80 : 8'($urandom);
                b8 = (i == 0) ? 8'h80 : 8'($urandom);
                m8 = (i == 0) ? 1'b1 : 1'($urandom % 2);
                ref_mul(8, 16, m8, longint'(a8), longint'(b8), p, o);
                ep[i+1+L8] = p;
                eo[i+1+L8] = o;
            end else begin
                v8 = 1'b0;
            end
            @(posedge clk);
            #1;
            want_v = ep.exists(i + 1);
            total++;
            if (out_valid8 !== want_v) $display("FAIL wide_valid edge %0d got %b want %b", i + 1, out_valid8, want_v);
            else passed++;
            if (want_v) begin
                t = ep[i+1];
                total++;
                if (P8 !== t[15:0] || ovf8 !== eo[i+1])
                    $display("FAIL wide_product edge %0d got P=%0d ovf=%b want P=%0d ovf=%b", i + 1, P8, ovf8, t[15:0], eo[i+1]);
                else passed++;
            end
            if (i + 1 == 1 + L8) begin
                total++;
                if (P8 !== 16'd16384 || ovf8 !== 1'b0)
                    $display("FAIL wide_min_squared got P=%0d ovf=%b want P=16384 ovf=0", P8, ovf8);
                else passed++;
            end
        end
    endtask

    initial begin
        test_reset;
        test_signed_sweep;
        test_unsigned;
        test_alternating;
        test_stall;
        test_random_stall;
        test_async_reset;
        test_wide;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
